// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared FSM states and memory geometry for mem_arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WIDX_W = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_addr_check.sv
// rtl/mem_arbiter_addr_check.sv - alignment and range fault detection for a byte address
module mem_arbiter_addr_check
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_fault
);

  localparam logic [ADDR_W-3:0] LP_DEPTH = (ADDR_W-2)'(DEPTH_WORDS);

  assign o_fault = (i_addr[1:0] != 2'b00) || (i_addr[ADDR_W-1:2] >= LP_DEPTH);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter onto one synchronous single-port memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WIDX_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t         r_state;
  logic [CNT_W-1:0]   r_starve;
  logic               r_err;
  logic               r_rd;

  logic               w_idle;
  logic               w_grant_d;
  logic               w_grant_i;
  logic               w_fault;
  logic               w_access;
  logic [ADDR_W-1:0]  w_addr;

  // Reset gates the combinational grant so ready drops the instant reset asserts.
  assign w_idle    = (r_state == IDLE) && !reset;
  assign w_grant_d = w_idle && d_req && !(i_req && (r_starve == LP_LIMIT));
  assign w_grant_i = w_idle && i_req && !w_grant_d;
  assign w_addr    = w_grant_d ? d_addr : i_addr;
  assign w_access  = (w_grant_d || w_grant_i) && !w_fault;

  mem_arbiter_addr_check #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_addr_check (
    .i_addr (w_addr),
    .o_fault(w_fault)
  );

  assign i_ready   = w_grant_i;
  assign d_ready   = w_grant_d;
  assign mem_en    = w_access;
  assign mem_we    = w_access && w_grant_d && d_we;
  assign mem_waddr = w_access ? w_addr[WIDX_W+1:2] : '0;
  assign mem_wdata = (w_access && w_grant_d) ? d_wdata : '0;

  assign i_rvalid  = (r_state == SERVE_I);
  assign d_rvalid  = (r_state == SERVE_D);
  assign i_err     = i_rvalid && r_err;
  assign d_err     = d_rvalid && r_err;
  assign i_rdata   = (i_rvalid && r_rd) ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && r_rd) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= SERVE_D;
            r_err   <= w_fault;
            r_rd    <= !w_fault && !d_we;
            if (i_req && (r_starve != LP_LIMIT)) begin
              r_starve <= r_starve + CNT_W'(1);
            end
          end else if (w_grant_i) begin
            r_state  <= SERVE_I;
            r_err    <= w_fault;
            r_rd     <= !w_fault;
            r_starve <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int DEPTH = 1024;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] phys_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  bit          pend_valid = 0;
  bit          pend_is_d = 0;
  bit          pend_err = 0;
  logic [31:0] pend_data = '0;
  int          starve = 0;
  bit          i_acc = 0;
  bit          d_acc = 0;
  bit          grants [$];

  logic        s_i_ready, s_i_rvalid, s_i_err, s_d_rvalid, s_d_err, s_mem_en, s_mem_we;
  logic [31:0] s_d_rdata, s_mem_waddr;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys_mem[mem_waddr] <= mem_wdata;
      mem_rdata <= phys_mem[mem_waddr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_i_ready"},  32'(i_ready),  32'd0);
    check_eq({tag, "_d_ready"},  32'(d_ready),  32'd0);
    check_eq({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
    check_eq({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    check_eq({tag, "_i_err"},    32'(i_err),    32'd0);
    check_eq({tag, "_d_err"},    32'(d_err),    32'd0);
    check_eq({tag, "_mem_en"},   32'(mem_en),   32'd0);
    check_eq({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check_eq({tag, "_waddr"},    32'(mem_waddr), 32'd0);
    check_eq({tag, "_wdata"},    mem_wdata,     32'd0);
    check_eq({tag, "_i_rdata"},  i_rdata,       32'd0);
    check_eq({tag, "_d_rdata"},  d_rdata,       32'd0);
  endtask

  // Reference: at most one outstanding transaction; answer arrives the cycle after grant.
  task automatic check_cycle();
    logic        e_ir = 0, e_dr = 0, e_iv = 0, e_dv = 0, e_ie = 0, e_de = 0, e_en = 0, e_we = 0;
    logic [31:0] e_ird = '0, e_drd = '0, e_wa = '0, e_wd = '0;
    logic [31:0] a;
    bit          fault, win_d, win_i;
    i_acc = 0;
    d_acc = 0;
    if (pend_valid) begin
      if (pend_is_d) begin e_dv = 1; e_de = pend_err; e_drd = pend_data; end
      else           begin e_iv = 1; e_ie = pend_err; e_ird = pend_data; end
      pend_valid = 0;
    end else begin
      win_d = d_req && !(i_req && starve == LIMIT);
      win_i = i_req && !win_d;
      if (win_d || win_i) begin
        a = win_d ? d_addr : i_addr;
        fault = (a % 4 != 0) || (a / 4 >= DEPTH);
        e_ir = win_i;
        e_dr = win_d;
        if (!fault) begin
          e_en = 1;
          e_wa = a / 4;
          e_we = win_d && d_we;
          if (win_d) e_wd = d_wdata;
        end
        pend_valid = 1;
        pend_is_d  = win_d;
        pend_err   = fault;
        pend_data  = (fault || (win_d && d_we)) ? 32'd0 : ref_mem[a / 4];
        if (!fault && win_d && d_we) ref_mem[a / 4] = d_wdata;
        if (win_d) begin
          if (i_req && starve < LIMIT) starve++;
        end else begin
          starve = 0;
        end
        i_acc = win_i;
        d_acc = win_d;
        grants.push_back(win_d);
      end
    end
    s_i_ready = i_ready; s_i_rvalid = i_rvalid; s_i_err = i_err;
    s_d_rvalid = d_rvalid; s_d_err = d_err; s_d_rdata = d_rdata;
    s_mem_en = mem_en; s_mem_we = mem_we; s_mem_waddr = 32'(mem_waddr);
    check_eq("i_ready",  32'(i_ready),  32'(e_ir));
    check_eq("d_ready",  32'(d_ready),  32'(e_dr));
    check_eq("i_rvalid", 32'(i_rvalid), 32'(e_iv));
    check_eq("d_rvalid", 32'(d_rvalid), 32'(e_dv));
    check_eq("i_err",    32'(i_err),    32'(e_ie));
    check_eq("d_err",    32'(d_err),    32'(e_de));
    check_eq("mem_en",   32'(mem_en),   32'(e_en));
    check_eq("mem_we",   32'(mem_we),   32'(e_we));
    if (e_iv) check_eq("i_rdata", i_rdata, e_ird);
    if (e_dv) check_eq("d_rdata", d_rdata, e_drd);
    if (e_en) begin
      check_eq("mem_waddr", 32'(mem_waddr), e_wa);
      check_eq("mem_wdata", mem_wdata, e_wd);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check_zero(tag);
    pend_valid = 0;
    starve = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (sel == 1) return 32'h1000 + 32'($urandom_range(0, 4000) * 4);
    if (sel == 2) return 32'h0000_0FFC;
    return 32'($urandom_range(0, 31) * 4);
  endfunction

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      phys_mem[k] = 32'(k) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[k]  = 32'(k) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    repeat (2) @(posedge clk);
    #1;
    apply_reset("reset");

    // Lone fetch at address 0
    i_req = 1; i_addr = 32'h0;
    step();
    i_req = 0;
    check_eq("030_i_ready", 32'(s_i_ready), 32'd1);
    step();
    check_eq("030_i_rvalid", 32'(s_i_rvalid), 32'd1);

    // Store then load 0x10
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    step();
    d_req = 0;
    check_eq("025_st_waddr", s_mem_waddr, 32'd4);
    check_eq("025_st_we", 32'(s_mem_we), 32'd1);
    step();
    check_eq("025_st_rvalid", 32'(s_d_rvalid), 32'd1);
    d_req = 1; d_we = 0; d_addr = 32'h10;
    step();
    d_req = 0;
    check_eq("025_ld_waddr", s_mem_waddr, 32'd4);
    step();
    check_eq("025_ld_rvalid", 32'(s_d_rvalid), 32'd1);
    check_eq("025_ld_rdata", s_d_rdata, 32'hDEADBEEF);
    check_eq("025_ld_err", 32'(s_d_err), 32'd0);

    // Misaligned load
    d_req = 1; d_we = 0; d_addr = 32'h13;
    step();
    d_req = 0;
    check_eq("027_mem_en", 32'(s_mem_en), 32'd0);
    step();
    check_eq("027_rvalid", 32'(s_d_rvalid), 32'd1);
    check_eq("027_err", 32'(s_d_err), 32'd1);
    check_eq("027_rdata", s_d_rdata, 32'd0);

    // Out-of-range fetch
    i_req = 1; i_addr = 32'h1000;
    step();
    i_req = 0;
    check_eq("028_mem_en", 32'(s_mem_en), 32'd0);
    step();
    check_eq("028_i_err", 32'(s_i_err), 32'd1);

    // Both held: data wins LIMIT times, then fetch
    apply_reset("rst2");
    grants.delete();
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 0; d_addr = 32'h24;
    repeat (20) step();
    i_req = 0; d_req = 0;
    step();
    check_eq("026_count", 32'(grants.size()), 32'd10);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      check_eq($sformatf("026_grant%0d", k), 32'(grants[k]), 32'((k % 5) != 4));

    // Reset asserted during SERVE_D
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = $urandom;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_zero("029_mid");
    pend_valid = 0;
    starve = 0;
    d_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    i_req = 1; i_addr = 32'h8;
    step();
    i_req = 0;
    check_eq("029_after_ready", 32'(s_i_ready), 32'd1);
    step();

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (!i_req || i_acc) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = rand_addr();
      end
      if (!d_req || d_acc) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      step();
    end
    i_req = 0; d_req = 0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, 1024, number of 32-bit words in the shared memory.
REQ-002 SHALL have parameter STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits.
REQ-003 SHALL have port clk, input, 1, single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_req / i_addr, input, 1 / 32, instruction-fetch request and byte address.
REQ-006 SHALL have ports i_ready / i_rvalid / i_rdata / i_err, output, 1 / 1 / 32 / 1, fetch accept, response strobe, data, fault.
REQ-007 SHALL have ports d_req / d_we / d_addr / d_wdata, input, 1 / 1 / 32 / 32, load/store request, write enable, byte address, store data.
REQ-008 SHALL have ports d_ready / d_rvalid / d_rdata / d_err, output, 1 / 1 / 32 / 1, load/store accept, response strobe, data, fault.
REQ-009 SHALL have ports mem_en / mem_we / mem_waddr / mem_wdata, output, 1 / 1 / 10 / 32, single-port memory enable, write, word index, write data.
REQ-010 SHALL have port mem_rdata, input, 32, synchronous-read data, valid the cycle after mem_en.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; only one transaction outstanding.
REQ-012 SHALL assert i_ready and d_ready only in IDLE, and only to the granted requester; a request is accepted on a rising edge with req and ready both high.
REQ-013 SHALL grant data over instruction when both request in the same IDLE cycle, unless the starvation counter equals STARVE_LIMIT, in which case instruction wins.
REQ-014 SHALL increment the starvation counter on each data grant while i_req is high, clear it on every instruction grant, and saturate at STARVE_LIMIT.
REQ-015 SHALL, on the accept cycle, drive mem_en=1, mem_waddr=addr[11:2], mem_we=d_we (0 for fetch), mem_wdata=d_wdata; mem_en=0 in all other cycles.
REQ-016 SHALL pulse the winner's rvalid for exactly one cycle, one cycle after accept (latency 1), with rdata=mem_rdata for reads and rdata=0 for writes, then return to IDLE.
REQ-017 SHALL treat addr[1:0]!=0 or word index >= DEPTH_WORDS as a fault: no mem_en, rvalid with err=1 and rdata=0 one cycle after accept.
REQ-018 SHALL keep err low on every non-faulting response; fetches never write memory.
REQ-019 SHALL give back-to-back throughput of one transaction per two cycles (accept, respond).
REQ-020 SHALL ignore request-input changes while not in IDLE; a requester holds req until accepted.

Reset
REQ-021 SHALL on reset force IDLE, clear the starvation counter, and drive all ready, rvalid, err, mem_en and mem_we to 0 and all data/address outputs to 0.
REQ-022 SHALL, when reset asserts mid-transaction, abandon it without a response; memory contents are not touched by this block.

Structure
REQ-023 SHALL place the FSM state enum and the fault-check word-index width constant in a shared package with the other memory definitions.
REQ-024 SHALL be a single module; a separate addr_check sub-module (alignment/range) is permitted and natural.

Verification
REQ-025 SHALL cover: d_req store addr 0x10 data 0xDEADBEEF, then load 0x10 -> mem_waddr=4, d_rvalid one cycle after each accept, load rdata=0xDEADBEEF, err=0.
REQ-026 SHALL cover: i_req and d_req both held high continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-027 SHALL cover: d_req load addr 0x13 -> no mem_en, d_rvalid=1 and d_err=1 next cycle, d_rdata=0.
REQ-028 SHALL cover: i_req addr 0x1000 (index 1024) -> i_err=1, no memory access.
REQ-029 SHALL cover: reset asserted asynchronously in the SERVE_D cycle -> outputs 0 immediately, no d_rvalid, FSM IDLE after release.
REQ-030 SHALL cover: lone i_req at addr 0x0 while idle -> i_ready same cycle, i_rvalid next cycle, starvation counter stays 0.
